// File: rtl/execute_muldiv_unit.sv
// Iterative multiply/divide unit for the execute stage.
// Multiply-class ops finish after a fixed MUL_LATENCY; divides run a 32-step
// restoring divider on operand magnitudes followed by a one-cycle sign fixup.
// MUL_LATENCY must lie in 1..256 (the step counter is 8 bits wide).
module execute_muldiv_unit #(
    parameter int unsigned MUL_LATENCY = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    input  logic [31:0] hi_in,
    input  logic [31:0] lo_in,
    input  logic        stall,
    input  logic        bubble,
    input  logic        nullify,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out
);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StMul   = 3'd1;
    localparam logic [2:0] StDiv   = 3'd2;
    localparam logic [2:0] StFixup = 3'd3;
    localparam logic [2:0] StDone  = 3'd4;

    localparam logic [7:0] MulLast = 8'(MUL_LATENCY - 1);
    localparam logic [7:0] DivLast = 8'd31;

    logic [2:0]  state_q, state_d;
    logic [7:0]  cnt_q;
    logic [2:0]  op_q;
    logic [31:0] a_q, b_q;
    logic [63:0] acc_q;
    logic [31:0] rem_q, quo_q, den_q;

    logic        accept;
    logic        in_div, in_div_signed;
    logic [31:0] abs_rs, abs_rt;

    logic        mul_signed;
    logic [63:0] mul_a, mul_b, product, mul_res;

    logic [32:0] rem_shift, rem_sub;
    logic        take;
    logic [31:0] rem_next, quo_next;

    logic        div_signed;
    logic [31:0] q_fix, r_fix;

    // Operand capture decision and divider magnitudes for the incoming op.
    always_comb begin
        accept        = (state_q == StIdle || state_q == StDone) && start && !bubble && !nullify;
        in_div        = (op[2:1] == 2'b01);
        in_div_signed = (op == 3'd2);
        abs_rs        = (in_div_signed && rs[31]) ? (~rs + 32'd1) : rs;
        abs_rt        = (in_div_signed && rt[31]) ? (~rt + 32'd1) : rt;
    end

    // 64-bit product of the latched operands, optionally accumulated into {hi,lo}.
    always_comb begin
        mul_signed = ~op_q[0];
        mul_a      = mul_signed ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
        mul_b      = mul_signed ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
        product    = mul_a * mul_b;
        case (op_q[2:1])
            2'b10:   mul_res = acc_q + product;
            2'b11:   mul_res = acc_q - product;
            default: mul_res = product;
        endcase
    end

    // One restoring-division step; bit 32 of the difference is the borrow.
    always_comb begin
        rem_shift = {rem_q, quo_q[31]};
        rem_sub   = rem_shift - {1'b0, den_q};
        take      = ~rem_sub[32];
        rem_next  = take ? rem_sub[31:0] : rem_shift[31:0];
        quo_next  = {quo_q[30:0], take};
    end

    // Sign correction of the magnitude quotient/remainder for DIV.
    always_comb begin
        div_signed = (op_q == 3'd2);
        q_fix      = (div_signed && (a_q[31] ^ b_q[31])) ? (~quo_q + 32'd1) : quo_q;
        r_fix      = (div_signed && a_q[31]) ? (~rem_q + 32'd1) : rem_q;
    end

    // Next-state: nullify wins over everything; DONE holds while stalled or restarted.
    always_comb begin
        state_d = state_q;
        if (nullify) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle: begin
                    if (accept) state_d = in_div ? StDiv : StMul;
                end
                StMul: begin
                    if (cnt_q == MulLast) state_d = StDone;
                end
                StDiv: begin
                    if (cnt_q == DivLast) state_d = StFixup;
                end
                StFixup: state_d = StDone;
                StDone: begin
                    if (accept) state_d = in_div ? StDiv : StMul;
                    else if (!stall && !start) state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // State, operand latches, iteration datapath and result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= 8'd0;
            op_q    <= 3'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            acc_q   <= 64'd0;
            rem_q   <= 32'd0;
            quo_q   <= 32'd0;
            den_q   <= 32'd0;
            hi_out  <= 32'd0;
            lo_out  <= 32'd0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q  <= op;
                a_q   <= rs;
                b_q   <= rt;
                acc_q <= {hi_in, lo_in};
                cnt_q <= 8'd0;
                rem_q <= 32'd0;
                quo_q <= abs_rs;
                den_q <= abs_rt;
            end else if (!nullify) begin
                case (state_q)
                    StMul: begin
                        cnt_q <= cnt_q + 8'd1;
                        if (cnt_q == MulLast) {hi_out, lo_out} <= mul_res;
                    end
                    StDiv: begin
                        cnt_q <= cnt_q + 8'd1;
                        rem_q <= rem_next;
                        quo_q <= quo_next;
                    end
                    StFixup: begin
                        hi_out <= r_fix;
                        lo_out <= q_fix;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Status flags decoded straight from the state register.
    always_comb begin
        busy = (state_q == StMul) || (state_q == StDiv) || (state_q == StFixup);
        done = (state_q == StDone);
    end

endmodule

// File: tb/tb_execute_muldiv_unit.sv
// Directed bench for execute_muldiv_unit: expected results are queued when an
// op is launched and compared (value and latency) when done appears.
module tb_execute_muldiv_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs, rt, hi_in, lo_in;
    logic        stall, bubble, nullify;
    logic        busy, done;
    logic [31:0] hi_out, lo_out;

    typedef struct {
        string       tag;
        logic [63:0] exp;
        int          lat;
    } sb_t;

    sb_t sb_q[$];
    int  checks = 0;
    int  errors = 0;

    execute_muldiv_unit #(.MUL_LATENCY(3)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .rs      (rs),
        .rt      (rt),
        .hi_in   (hi_in),
        .lo_in   (lo_in),
        .stall   (stall),
        .bubble  (bubble),
        .nullify (nullify),
        .busy    (busy),
        .done    (done),
        .hi_out  (hi_out),
        .lo_out  (lo_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference result {hi,lo} built from plain arithmetic operators.
    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] h,
                                          input logic [31:0] l);
        longint      sa, sb;
        int          ia, ib, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ia = int'(a);
        ib = int'(b);
        case (o)
            3'd0, 3'd4, 3'd6: p = 64'(sa * sb);
            default:          p = {32'd0, a} * {32'd0, b};
        endcase
        case (o)
            3'd0, 3'd1: return p;
            3'd4, 3'd5: return {h, l} + p;
            3'd6, 3'd7: return {h, l} - p;
            3'd2: begin
                if (b == 32'd0) return {a, (a[31] ? 32'd1 : 32'hFFFF_FFFF)};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                q = ia / ib;
                r = ia % ib;
                return {32'(r), 32'(q)};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    task automatic push(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] h, input logic [31:0] l);
        sb_t e;
        e.tag = tag;
        e.exp = model(o, a, b, h, l);
        e.lat = (o == 3'd2 || o == 3'd3) ? 33 : 3;
        sb_q.push_back(e);
    endtask

    task automatic drive(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] h, input logic [31:0] l);
        op    = o;
        rs    = a;
        rt    = b;
        hi_in = h;
        lo_in = l;
        start = 1'b1;
    endtask

    // Called right after the accept edge; bounded wait for done, then compare.
    task automatic wait_and_check();
        int  cyc;
        sb_t e;
        cyc = 0;
        while (!done && cyc < 60) begin
            tick();
            cyc++;
        end
        e = sb_q.pop_front();
        chk({e.tag, "_done"}, 64'(done), 64'd1);
        chk({e.tag, "_lat"}, 64'(cyc), 64'(e.lat));
        chk({e.tag, "_hi"}, 64'(hi_out), 64'(e.exp[63:32]));
        chk({e.tag, "_lo"}, 64'(lo_out), 64'(e.exp[31:0]));
    endtask

    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] h, input logic [31:0] l);
        push(tag, o, a, b, h, l);
        drive(o, a, b, h, l);
        tick();
        start = 1'b0;
        chk({tag, "_busy"}, 64'(busy), 64'd1);
        wait_and_check();
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op = 3'd0; rs = '0; rt = '0; hi_in = '0; lo_in = '0;
        stall = 1'b0; bubble = 1'b0; nullify = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_hi", 64'(hi_out), 64'd0);
        chk("rst_lo", 64'(lo_out), 64'd0);

        // Spot values from the datasheet examples.
        run_op("mult",  3'd0, 32'hFFFF_FFFE, 32'd3, 32'd0, 32'd0);
        chk("mult_hi_k", 64'(hi_out), 64'hFFFF_FFFF);
        chk("mult_lo_k", 64'(lo_out), 64'hFFFF_FFFA);
        run_op("multu", 3'd1, 32'hFFFF_FFFE, 32'd3, 32'd0, 32'd0);
        chk("multu_hi_k", 64'(hi_out), 64'h2);
        run_op("maddu", 3'd5, 32'd1, 32'd1, 32'd0, 32'hFFFF_FFFF);
        chk("maddu_k", {32'(hi_out), 32'(lo_out)}, 64'h1_0000_0000);
        run_op("msub",  3'd6, 32'd1, 32'd1, 32'd0, 32'd0);
        chk("msub_k", {32'(hi_out), 32'(lo_out)}, 64'hFFFF_FFFF_FFFF_FFFF);
        run_op("div",   3'd2, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'd0);
        chk("div_k", {32'(hi_out), 32'(lo_out)}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op("divu0", 3'd3, 32'd7, 32'd0, 32'd0, 32'd0);
        chk("divu0_k", {32'(hi_out), 32'(lo_out)}, 64'h7_FFFF_FFFF);

        // Idle release: done drops, result stays.
        tick();
        chk("release_done", 64'(done), 64'd0);
        chk("release_hi", 64'(hi_out), 64'd7);

        // Bubbles block accept; stall held throughout does not slow the divider.
        stall = 1'b1;
        bubble = 1'b1;
        push("bubble_divu", 3'd3, 32'd100, 32'd7, 32'd0, 32'd0);
        drive(3'd3, 32'd100, 32'd7, 32'd0, 32'd0);
        tick();
        chk("bubble1_busy", 64'(busy), 64'd0);
        tick();
        chk("bubble2_busy", 64'(busy), 64'd0);
        bubble = 1'b0;
        tick();
        start = 1'b0;
        chk("bubble_accept_busy", 64'(busy), 64'd1);
        wait_and_check();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_hold_done", 64'(done), 64'd1);
            chk("stall_hold_res", {32'(hi_out), 32'(lo_out)}, {32'd2, 32'd14});
        end
        stall = 1'b0;
        tick();
        chk("unstall_done", 64'(done), 64'd0);

        // Nullify at DIV cycle 10, then an immediate MULT.
        drive(3'd2, 32'd1000, 32'd3, 32'd0, 32'd0);
        tick();
        start = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        chk("pre_null_busy", 64'(busy), 64'd1);
        nullify = 1'b1;
        tick();
        nullify = 1'b0;
        chk("null_busy", 64'(busy), 64'd0);
        chk("null_done", 64'(done), 64'd0);
        run_op("post_null_mult", 3'd0, 32'd5, 32'hFFFF_FFFD, 32'd0, 32'd0);

        // Reset in the middle of a divide.
        drive(3'd2, 32'd12345, 32'd17, 32'd0, 32'd0);
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        chk("midrst_hi", 64'(hi_out), 64'd0);
        chk("midrst_lo", 64'(lo_out), 64'd0);

        run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0);
        chk("div_ovf_k", {32'(hi_out), 32'(lo_out)}, 64'h0000_0000_8000_0000);
        run_op("div_neg0", 3'd2, 32'hFFFF_FFF9, 32'd0, 32'd0, 32'd0);

        // A few pseudo-random ops against the arithmetic model.
        for (int i = 0; i < 8; i++) begin
            run_op("rand", 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom, $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
